// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_pkg
// Brief    : Shared constants and types for the score display path.
// Revision : 1.0
// ============================================================================
package score_pkg;

    localparam int SCORE_W_DEF = 14;
    localparam int DIGITS_DEF  = 4;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : BCD digit to active-low seven-segment pattern; non-BCD codes blank.
// Revision : 1.0
// ============================================================================
module seg7_decode
    import score_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module   : score_display
// Brief    : Sequential binary-to-BCD conversion of score/high score driving a
//            multiplexed active-low seven-segment display.
// Revision : 1.0
// ============================================================================
module score_display
    import score_pkg::*;
#(
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int DIGITS      = DIGITS_DEF,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [SCORE_W-1:0] high_in,
    input  logic               show_high,
    input  logic               load,
    output logic               busy,
    output logic               bcd_valid,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  an,
    output logic               dp
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(SCORE_W + 1);
    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SCORE_W-1:0] c_SAT_MAX  = SCORE_W'(10**DIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(SCORE_W - 1);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic                         w_start;
    logic                         w_use_high;
    logic [SCORE_W-1:0]           w_sel;
    logic [SCORE_W-1:0]           w_sat;
    logic [SCORE_W-1:0]           r_bin;
    logic [c_BCD_W-1:0]           r_bcd;
    logic [c_BCD_W-1:0]           w_adj;
    logic [c_BCD_W+SCORE_W-1:0]   w_shift;
    logic [c_BCD_W-1:0]           r_disp;
    logic [c_CNT_W-1:0]           r_cnt;
    logic                         r_pending;
    logic                         r_pend_high;
    logic                         r_bcd_valid;
    logic [c_REF_W-1:0]           r_refresh;
    logic [c_IDX_W-1:0]           r_idx;
    logic [3:0]                   w_nib;
    logic                         w_upper_zero;
    logic                         w_blank;
    logic [6:0]                   w_dec;
    logic [DIGITS-1:0]            w_an;
    logic [6:0]                   r_seg;
    logic [DIGITS-1:0]            r_an;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load || r_pending) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_LAST_BIT) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A fresh load overrides the selection latched by an earlier pending request
    assign w_use_high = load ? show_high : r_pend_high;
    assign w_sel      = w_use_high ? high_in : score_in;
    assign w_sat      = (w_sel > c_SAT_MAX) ? c_SAT_MAX : w_sel;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shift = {w_adj, r_bin} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_disp      <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_bin <= w_sat;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= w_shift;
                    r_cnt          <= r_cnt + 1'b1;
                end
                ST_DONE: begin
                    r_disp      <= r_bcd;
                    r_bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= 1'b0;
            r_pend_high <= 1'b0;
        end else if (load && (r_state != ST_IDLE)) begin
            r_pending   <= 1'b1;
            r_pend_high <= show_high;
        end else if (w_start) begin
            r_pending   <= 1'b0;
        end
    end

    always_comb begin
        w_nib        = 4'd0;
        w_upper_zero = 1'b1;
        w_an         = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c_IDX_W'(i) == r_idx) begin
                w_nib   = r_disp[4*i +: 4];
                w_an[i] = 1'b0;
            end
            if ((c_IDX_W'(i) >= r_idx) && (r_disp[4*i +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_blank = BLANK_LZ && (r_idx != '0) && w_upper_zero;

    seg7_decode u_seg7_decode (
        .i_bcd (w_nib),
        .o_seg (w_dec)
    );

    // seg and an share one register stage so they always switch together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_seg     <= SEG_BLANK;
            r_an      <= '1;
        end else begin
            r_seg <= w_blank ? SEG_BLANK : w_dec;
            r_an  <= w_an;
            if (r_refresh == c_REF_LAST) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
        end
    end

    assign busy      = (r_state == ST_SHIFT);
    assign bcd_valid = r_bcd_valid;
    assign seg       = r_seg;
    assign an        = r_an;
    assign dp        = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_display
// Brief    : Self-checking bench for score_display with a bcd_valid scoreboard.
// Revision : 1.0
// ============================================================================
module tb_score_display;

    localparam int SCORE_W     = 14;
    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;

    logic               clk       = 1'b0;
    logic               rst       = 1'b1;
    logic [SCORE_W-1:0] score_in  = '0;
    logic [SCORE_W-1:0] high_in   = '0;
    logic               show_high = 1'b0;
    logic               load      = 1'b0;
    logic               busy;
    logic               bcd_valid;
    logic [6:0]         seg;
    logic [DIGITS-1:0]  an;
    logic               dp;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   pulses   = 0;
    int   disp_exp = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    score_display #(
        .SCORE_W     (SCORE_W),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .score_in  (score_in),
        .high_in   (high_in),
        .show_high (show_high),
        .load      (load),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each bcd_valid pulse must match the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (bcd_valid === 1'b1) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bcd_valid_unexpected: pulse at cycle %0d, required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL bcd_valid_latency: pulse at cycle %0d, required %0d", cyc, e.cyc);
                    end
                    disp_exp = e.val;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input bit h);
        int sel;
        sel = h ? int'(high_in) : int'(score_in);
        if (sel > 9999) sel = 9999;
        show_high = h;
        load      = 1'b1;
        exp_q.push_back('{sel, cyc + 16});
        tick();
        load      = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_idle: %0d conversions outstanding after %0d cycles, required 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic check_display(input string nm);
        logic [3:0] prev;
        logic [6:0] es;
        int         idx;
        int         dig;
        int         p10;
        prev = 4'hF;
        for (int t = 0; t < 4 * REFRESH_DIV + 2; t++) begin
            tick();
            idx = -1;
            for (int i = 0; i < DIGITS; i++) begin
                if (an === ~(4'b0001 << i)) idx = i;
            end
            checks++;
            if (idx < 0) begin
                errors++;
                $display("FAIL %s_an_onehot: an=%b, required one-hot low", nm, an);
            end else begin
                p10 = 10 ** idx;
                dig = (disp_exp / p10) % 10;
                es  = (idx > 0 && disp_exp < p10) ? 7'h7F : seg_tab[dig];
                checks++;
                if (seg !== es) begin
                    errors++;
                    $display("FAIL %s_seg: digit %0d seg=%h, required %h (value %0d)",
                             nm, idx, seg, es, disp_exp);
                end
                if (prev != 4'hF && an != prev) begin
                    checks++;
                    if (an !== {prev[2:0], prev[3]}) begin
                        errors++;
                        $display("FAIL %s_an_order: an=%b after %b, required %b",
                                 nm, an, prev, {prev[2:0], prev[3]});
                    end
                end
                prev = an;
            end
        end
        checks++;
        if (dp !== 1'b1) begin
            errors++;
            $display("FAIL %s_dp: dp=%b, required 1", nm, dp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (seg !== 7'h7F || an !== 4'hF) begin
            errors++;
            $display("FAIL reset_outputs: seg=%h an=%b, required 7f 1111", seg, an);
        end
        checks++;
        if (busy !== 1'b0 || bcd_valid !== 1'b0 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: busy=%b bcd_valid=%b dp=%b, required 0 0 1",
                     busy, bcd_valid, dp);
        end
        rst      = 1'b0;
        disp_exp = 0;
        tick();
        checks++;
        if (an !== 4'b1110 || seg !== 7'h40) begin
            errors++;
            $display("FAIL reset_first_slot: an=%b seg=%h, required 1110 40", an, seg);
        end
        check_display("reset");
    endtask

    task automatic test_basic;
        score_in = 14'd1234;
        do_load(1'b0);
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (busy !== (i < 14)) begin
                errors++;
                $display("FAIL basic_busy: cycle +%0d busy=%b, required %b", i, busy, (i < 14));
            end
            tick();
        end
        wait_idle(30);
        check_display("basic");
    endtask

    task automatic test_saturate;
        score_in = 14'd42;
        high_in  = 14'd16383;
        do_load(1'b1);
        wait_idle(40);
        check_display("saturate");
        score_in = 14'd9000;
        high_in  = 14'd25;
        do_load(1'b1);
        wait_idle(40);
        check_display("select_high");
    endtask

    task automatic test_values;
        int vals [5] = '{100, 9999, 10000, 0, 7};
        for (int v = 0; v < 5; v++) begin
            score_in = 14'(vals[v]);
            do_load(1'b0);
            wait_idle(40);
            check_display("values");
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        int p0;
        p0       = pulses;
        c0       = cyc;
        score_in = 14'd50;
        do_load(1'b0);
        repeat (2) tick();
        score_in = 14'd51;
        load     = 1'b1;
        exp_q.push_back('{51, c0 + 32});
        tick();
        load     = 1'b0;
        wait_idle(60);
        repeat (20) tick();
        checks++;
        if (pulses - p0 != 2) begin
            errors++;
            $display("FAIL b2b_pulses: %0d bcd_valid pulses, required 2", pulses - p0);
        end
        check_display("b2b");
    endtask

    task automatic test_reset_mid;
        int p0;
        score_in = 14'd777;
        do_load(1'b0);
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy_async: busy=%b, required 0", busy);
        end
        exp_q.delete();
        repeat (2) tick();
        rst      = 1'b0;
        disp_exp = 0;
        p0       = pulses;
        repeat (30) tick();
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL midrst_no_valid: %0d pulses, required 0", pulses - p0);
        end
        check_display("midrst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_values();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
